inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue.sv | 146 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// In-order instruction queue between instruction memory and decode; presents the head word split into MIPS R/I/J fields.
// Optional per-entry PC tagging is enabled with the IFQ_PC_TAG_EN macro (adds in_pc/out_pc).
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
`ifdef IFQ_PC_TAG_EN
  input  logic [31:0]      in_pc,
  output logic [31:0]      out_pc,
`endif
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm,
  output logic [25:0]      target,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_r [DEPTH];
`ifdef IFQ_PC_TAG_EN
  logic [31:0]      pc_mem_r [DEPTH];
`endif
  logic [PTR_W-1:0] wp_r;
  logic [PTR_W-1:0] rp_r;
  logic [CNT_W-1:0] count_r;

  logic             push_s;
  logic             pop_s;
  logic [PTR_W-1:0] wp_nxt_s;
  logic [PTR_W-1:0] rp_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [31:0]      head_s;

  assign in_ready  = (count_r < CNT_W'(DEPTH));
  assign out_valid = (count_r != {CNT_W{1'b0}});
  assign count     = count_r;

  // Handshake qualification; flush suppresses both sides so nothing is stored or consumed
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (flush) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = in_valid & in_ready;
      pop_s  = out_valid & out_ready;
    end
  end

  // Next pointer and occupancy; pointers wrap naturally at the power-of-two depth
  always_comb begin
    wp_nxt_s    = wp_r;
    rp_nxt_s    = rp_r;
    count_nxt_s = count_r;
    if (flush) begin
      wp_nxt_s    = {PTR_W{1'b0}};
      rp_nxt_s    = {PTR_W{1'b0}};
      count_nxt_s = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wp_nxt_s = wp_r + PTR_W'(1);
      end else begin
        wp_nxt_s = wp_r;
      end
      if (pop_s) begin
        rp_nxt_s = rp_r + PTR_W'(1);
      end else begin
        rp_nxt_s = rp_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r    <= {PTR_W{1'b0}};
      rp_r    <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      wp_r    <= wp_nxt_s;
      rp_r    <= rp_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Entry storage is deliberately left unreset; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wp_r] <= in_inst;
`ifdef IFQ_PC_TAG_EN
      pc_mem_r[wp_r] <= in_pc;
`endif
    end
  end

  // Head word, forced to a NOP encoding while the queue is empty
  always_comb begin
    head_s = 32'd0;
    if (out_valid) begin
      head_s = mem_r[rp_r];
    end else begin
      head_s = 32'd0;
    end
  end

`ifdef IFQ_PC_TAG_EN
  // Head PC tag, zero while empty
  always_comb begin
    out_pc = 32'd0;
    if (out_valid) begin
      out_pc = pc_mem_r[rp_r];
    end else begin
      out_pc = 32'd0;
    end
  end
`endif

  assign op     = head_s[31:26];
  assign rs     = head_s[25:21];
  assign rt     = head_s[20:16];
  assign rd     = head_s[15:11];
  assign shamt  = head_s[10:6];
  assign funct  = head_s[5:0];
  assign imm    = head_s[15:0];
  assign target = head_s[25:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4); PC-tag checks compile only with IFQ_PC_TAG_EN.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic [31:0]      out_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       op;
  logic [4:0]       rs, rt, rd, shamt;
  logic [5:0]       funct;
  logic [15:0]      imm;
  logic [25:0]      target;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
`ifdef IFQ_PC_TAG_EN
    .in_pc(in_pc), .out_pc(out_pc),
`endif
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target), .count(count)
  );

`ifndef IFQ_PC_TAG_EN
  assign out_pc = 32'd0;
`endif

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_inst  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_word();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    push_word(32'hDEAD_0001);
    push_word(32'hDEAD_0002);
    in_valid = 1'b1; in_inst = 32'hDEAD_0003;
    #2 rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if ({op, target} !== 32'd0) begin n_fail++; $display("FAIL reset_fields got=%h exp=0", {op, target}); end
    tick();
    rst_n = 1'b1;
    tick();
    push_word(32'h012A_4020);
    n_checks++; if (op !== 6'd0) begin n_fail++; $display("FAIL add_op got=%0d exp=0", op); end
    n_checks++; if (rs !== 5'd9) begin n_fail++; $display("FAIL add_rs got=%0d exp=9", rs); end
    n_checks++; if (rt !== 5'd10) begin n_fail++; $display("FAIL add_rt got=%0d exp=10", rt); end
    n_checks++; if (rd !== 5'd8) begin n_fail++; $display("FAIL add_rd got=%0d exp=8", rd); end
    n_checks++; if (shamt !== 5'd0) begin n_fail++; $display("FAIL add_shamt got=%0d exp=0", shamt); end
    n_checks++; if (funct !== 6'h20) begin n_fail++; $display("FAIL add_funct got=%h exp=20", funct); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL add_count got=%0d exp=1", count); end
    pop_word();
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL add_pop got=%0d/%b exp=0/0", count, out_valid); end
    pop_word();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_pop_ignored got=%0d exp=0", count); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      push_word(32'h8C00_0000 + 32'(i));
      n_checks++; if (count !== 3'(i)) begin n_fail++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, count, i); end
    end
    in_valid = 1'b1; in_inst = 32'h8C00_0005;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold_count got=%0d exp=4", count); end
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (imm !== 16'(i) || op !== 6'h23) begin n_fail++; $display("FAIL fill_pop%0d got=%h/%h exp=23/%h", i, op, imm, i); end
      pop_word();
    end
    n_checks++; if (count !== 3'd0 || imm !== 16'd0) begin n_fail++; $display("FAIL fill_drained got=%0d/%h exp=0/0", count, imm); end
  endtask

  task automatic test_wrap();
    logic [31:0] q[$];
    logic [31:0] w;
    logic [31:0] nxt;
    nxt = 32'h2000_0100;
    for (int i = 0; i < 2; i++) begin
      push_word(nxt); q.push_back(nxt); nxt = nxt + 32'h0001_0003;
    end
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 2; s++) begin
        if ((s == 0) == (i % 2 == 0)) begin
          push_word(nxt); q.push_back(nxt); nxt = nxt + 32'h0001_0003;
        end else begin
          w = q.pop_front();
          n_checks++; if ({op, rs, rt, rd, shamt, funct} !== w) begin n_fail++; $display("FAIL wrap_head%0d got=%h exp=%h", i, {op, rs, rt, rd, shamt, funct}, w); end
          pop_word();
        end
        n_checks++; if (count !== 3'(q.size()) || count > 3'd4) begin n_fail++; $display("FAIL wrap_count%0d got=%0d exp=%0d", i, count, q.size()); end
      end
    end
    while (q.size() > 0) begin
      w = q.pop_front();
      n_checks++; if ({op, target} !== w) begin n_fail++; $display("FAIL wrap_drain got=%h exp=%h", {op, target}, w); end
      pop_word();
    end
  endtask

  task automatic test_back_to_back();
    push_word(32'h3C01_000A);
    push_word(32'h3C01_000B);
    in_valid = 1'b1; in_inst = 32'h3C01_000C; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd2 || imm !== 16'h000B) begin n_fail++; $display("FAIL pp_mid got=%0d/%h exp=2/000b", count, imm); end
    push_word(32'h3C01_000D);
    push_word(32'h3C01_000E);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL pp_fill got=%0d exp=4", count); end
    in_valid = 1'b1; in_inst = 32'h3C01_000F; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd3 || imm !== 16'h000C) begin n_fail++; $display("FAIL pp_full got=%0d/%h exp=3/000c", count, imm); end
    for (int i = 12; i <= 14; i++) begin
      n_checks++; if (imm !== 16'(i)) begin n_fail++; $display("FAIL pp_drain got=%h exp=%h", imm, i); end
      pop_word();
    end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL pp_reject got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
    push_word(32'h3333_3333);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre got=%0d exp=3", count); end
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0800_0010; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state got=%0d/%b/%b exp=0/0/1", count, out_valid, in_ready); end
    n_checks++; if ({op, rs, rt, rd, shamt, funct, imm, target} !== 74'd0) begin n_fail++; $display("FAIL flush_fields got=%h exp=0", {op, target}); end
    push_word(32'h0800_0010);
    n_checks++; if (op !== 6'd2 || target !== 26'h10 || count !== 3'd1) begin n_fail++; $display("FAIL flush_repush got=%h/%h/%0d exp=2/10/1", op, target, count); end
    pop_word();
  endtask

  task automatic test_pc();
`ifdef IFQ_PC_TAG_EN
    in_pc = 32'h0040_0000; push_word(32'h2408_0001);
    in_pc = 32'h0040_0004; push_word(32'h2408_0002);
    n_checks++; if (out_pc !== 32'h0040_0000) begin n_fail++; $display("FAIL pc_head0 got=%h exp=00400000", out_pc); end
    pop_word();
    n_checks++; if (out_pc !== 32'h0040_0004 || imm !== 16'd2) begin n_fail++; $display("FAIL pc_head1 got=%h/%h exp=00400004/2", out_pc, imm); end
    pop_word();
    n_checks++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL pc_empty got=%h exp=0", out_pc); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_pc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
